item_inventory: RTL and testbench
=================================

// Module: item_inventory
// PURPOSE
//   Parametrised multi-item inventory tracker for the adventure-game FSM set.
//   Each of NUM_ITEMS slots holds a saturating count, not a one-shot flag.
//   Items are acquired by pick pulses and consumed by use pulses.
//   Provides per-item held/found status, an all-found flag and event pulses for the game controller.
// PARAMETERS
//   NUM_ITEMS  4  number of independent item slots (>=1)
//   CNT_W      3  count width per slot; MAX_CNT = 2**CNT_W-1 (CNT_W>=1)
// PORTS
//   clk        in   1                 clock, rising edge
//   reset      in   1                 asynchronous, active-high reset
//   clear      in   1                 synchronous clear of all slots and pulses
//   pick       in   NUM_ITEMS         per-slot acquire request, 1 item per cycle
//   use_req    in   NUM_ITEMS         per-slot consume request, 1 item per cycle
//   count      out  NUM_ITEMS*CNT_W   slot i count at [i*CNT_W +: CNT_W]
//   have       out  NUM_ITEMS         slot state != SLOT_EMPTY
//   found      out  NUM_ITEMS         item-found status (see CONFIGURATION)
//   all_found  out  1                 &found
//   new_item   out  1                 1-cycle pulse: some slot left SLOT_EMPTY last edge
//   use_denied out  NUM_ITEMS         1-cycle pulse: use_req on an empty slot, not covered by pick
//   overflow   out  NUM_ITEMS         1-cycle pulse: pick on a SLOT_FULL slot, not offset by use_req
// BEHAVIOUR
//   Reset (async) and clear (sync):
//     - all slots go to SLOT_EMPTY and count=0.
//     - have=0, found=0, all_found=0, new_item=0, use_denied=0, overflow=0.
//     - clear has priority over pick/use_req in the same cycle.
//   Per-slot FSM (slot_state_t), one update per rising edge:
//     SLOT_EMPTY: pick & !use_req                 -> SLOT_HELD, count=1
//                 use_req & !pick                 -> stay; use_denied pulse
//                 pick & use_req                  -> stay, count=0; no deny (pick satisfies use)
//     SLOT_HELD:  pick & !use_req                 -> count+1; SLOT_FULL when count+1==MAX_CNT
//                 use_req & !pick                 -> count-1; SLOT_EMPTY when count-1==0
//                 pick & use_req                  -> unchanged
//     SLOT_FULL:  pick & !use_req                 -> stay at MAX_CNT; overflow pulse (saturate, no wrap)
//                 use_req                         -> MAX_CNT-1, SLOT_HELD (pick ignored if both set)
//     CNT_W==1:   slot goes SLOT_EMPTY <-> SLOT_FULL directly; SLOT_HELD is unreachable.
//   Timing:
//     - count, have, found and all_found reflect registered state; they change 1 cycle after the request edge.
//     - new_item, use_denied and overflow are registered.
//       They are high exactly the cycle after the causing edge, for 1 cycle only.
//   Slots are fully independent; simultaneous events on different slots are all honoured.
//   Reset mid-operation discards any in-flight pulse.
//   Count arithmetic is unsigned CNT_W bits, never wraps; count==0 iff SLOT_EMPTY.
// CONFIGURATION
//   INVENTORY_STICKY_EN defined:
//     - found[i] is a sticky register, set on the first SLOT_EMPTY->SLOT_HELD/SLOT_FULL transition.
//     - found[i] is cleared only by reset/clear. This is the legacy vorpal-sword semantics.
//     - all_found stays high after all items are ever found, even if they are later consumed.
//   INVENTORY_STICKY_EN undefined:
//     - found = have, combinational; no extra flops.
//     - all_found drops when any slot empties.
// STRUCTURE
//   Package inventory_pkg:
//     - typedef enum logic [1:0] {SLOT_EMPTY, SLOT_HELD, SLOT_FULL} slot_state_t.
//     - function max_cnt(CNT_W).
//   Sub-module inventory_slot:
//     - one slot: FSM, counter, deny/overflow pulse flops, sticky found flop.
//     - top instantiates NUM_ITEMS copies via generate.
//   Top owns: new_item OR-reduce flop, all_found reduction, count packing.
// TESTING
//   1. reset, then pick[0] for 1 cycle -> next cycle count0=1, have[0]=1, found[0]=1, new_item=1 for 1 cycle.
//   2. CNT_W=3, 9 consecutive pick[1] -> count1 saturates at 7, SLOT_FULL, overflow[1] pulses on pick 8 and 9.
//   3. use_req[2] on empty slot -> use_denied[2]=1 for 1 cycle, count2 stays 0; pick[2]&use_req[2] together -> no deny, count2=0.
//   4. NUM_ITEMS=4, pick all slots in the same cycle -> all_found=1 next cycle; then use_req[3] until empty.
//      Sticky build: all_found stays 1. Non-sticky build: all_found=0.
//   5. count0=5 with clear and pick[0] asserted together -> next cycle all counts 0, no pulses, all_found=0.
//   6. assert reset mid-burst of picks/uses -> outputs 0 asynchronously; first edge after release behaves as case 1.

Source files
------------

// File: rtl/item_inventory_pkg.sv
// Shared types and helpers for the multi-item inventory tracker.
package inventory_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_HELD  = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_state_t;

  // Largest value a slot counter of the given width can hold before saturating.
  function automatic int max_cnt(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/item_inventory_if.sv
// Request/status bundle between the game controller (master) and the inventory (slave).
interface item_inventory_if #(
  parameter int NUM_ITEMS = 4,
  parameter int CNT_W     = 3
);
  logic                       clear;
  logic [NUM_ITEMS-1:0]       pick;
  logic [NUM_ITEMS-1:0]       use_req;
  logic [NUM_ITEMS*CNT_W-1:0] count;
  logic [NUM_ITEMS-1:0]       have;
  logic [NUM_ITEMS-1:0]       found;
  logic                       all_found;
  logic                       new_item;
  logic [NUM_ITEMS-1:0]       use_denied;
  logic [NUM_ITEMS-1:0]       overflow;

  modport master (
    output clear, pick, use_req,
    input  count, have, found, all_found, new_item, use_denied, overflow
  );

  modport slave (
    input  clear, pick, use_req,
    output count, have, found, all_found, new_item, use_denied, overflow
  );
endinterface

// File: rtl/item_inventory_slot.sv
// One inventory slot: saturating counter FSM with deny/overflow pulses.
// With INVENTORY_STICKY_EN defined, found is a sticky flop; otherwise it mirrors have.
module inventory_slot
  import inventory_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_pick,
  input  logic             i_use_req,
  output logic [CNT_W-1:0] o_count,
  output logic             o_have,
  output logic             o_found,
  output logic             o_leave_empty,
  output logic             o_use_denied,
  output logic             o_overflow
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(max_cnt(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  slot_state_t      r_state;
  slot_state_t      w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_nextCount;
  logic             r_useDenied;
  logic             r_overflow;
  logic             w_deny;
  logic             w_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SLOT_EMPTY;
      r_count     <= '0;
      r_useDenied <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_count     <= w_nextCount;
      r_useDenied <= w_deny;
      r_overflow  <= w_ovf;
    end
  end

  // A simultaneous pick and use cancel out, except on a full slot where the use wins.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_deny      = 1'b0;
    w_ovf       = 1'b0;
    if (i_clear) begin
      w_nextState = SLOT_EMPTY;
      w_nextCount = '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (i_pick && !i_use_req) begin
            w_nextCount = ONE;
            w_nextState = (ONE == MAX) ? SLOT_FULL : SLOT_HELD;
          end else if (i_use_req && !i_pick) begin
            w_deny = 1'b1;
          end
        end
        SLOT_HELD: begin
          if (i_pick && !i_use_req) begin
            w_nextCount = r_count + ONE;
            if (w_nextCount == MAX) w_nextState = SLOT_FULL;
          end else if (i_use_req && !i_pick) begin
            w_nextCount = r_count - ONE;
            if (w_nextCount == '0) w_nextState = SLOT_EMPTY;
          end
        end
        SLOT_FULL: begin
          if (i_use_req) begin
            w_nextCount = MAX - ONE;
            w_nextState = (MAX == ONE) ? SLOT_EMPTY : SLOT_HELD;
          end else if (i_pick) begin
            w_ovf = 1'b1;
          end
        end
        default: begin
          w_nextState = SLOT_EMPTY;
          w_nextCount = '0;
        end
      endcase
    end
  end

  assign o_count       = r_count;
  assign o_have        = (r_state != SLOT_EMPTY);
  assign o_leave_empty = (r_state == SLOT_EMPTY) && (w_nextState != SLOT_EMPTY);
  assign o_use_denied  = r_useDenied;
  assign o_overflow    = r_overflow;

`ifdef INVENTORY_STICKY_EN
  logic r_found;

  // Latches the first acquisition; only reset or clear forgets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_found <= 1'b0;
    else if (i_clear) r_found <= 1'b0;
    else if (o_leave_empty) r_found <= 1'b1;
  end

  assign o_found = r_found;
`else
  assign o_found = o_have;
`endif

endmodule

// File: rtl/item_inventory.sv
// Multi-item inventory tracker: NUM_ITEMS independent slots plus shared event flags.
// Optional INVENTORY_STICKY_EN makes found/all_found sticky (handled inside each slot).
module item_inventory
  import inventory_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int CNT_W     = 3
) (
  input logic             clk,
  input logic             reset,
  item_inventory_if.slave bus
);

  logic [NUM_ITEMS*CNT_W-1:0] w_count;
  logic [NUM_ITEMS-1:0]       w_have;
  logic [NUM_ITEMS-1:0]       w_found;
  logic [NUM_ITEMS-1:0]       w_leave;
  logic [NUM_ITEMS-1:0]       w_deny;
  logic [NUM_ITEMS-1:0]       w_ovf;
  logic                       r_newItem;

  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_slot
    inventory_slot #(.CNT_W(CNT_W)) u_slot (
      .clk           (clk),
      .reset         (reset),
      .i_clear       (bus.clear),
      .i_pick        (bus.pick[gi]),
      .i_use_req     (bus.use_req[gi]),
      .o_count       (w_count[gi*CNT_W +: CNT_W]),
      .o_have        (w_have[gi]),
      .o_found       (w_found[gi]),
      .o_leave_empty (w_leave[gi]),
      .o_use_denied  (w_deny[gi]),
      .o_overflow    (w_ovf[gi])
    );
  end

  // Clear forces every slot to stay empty, so no leave event can slip through it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_newItem <= 1'b0;
    else       r_newItem <= |w_leave;
  end

  assign bus.count      = w_count;
  assign bus.have       = w_have;
  assign bus.found      = w_found;
  assign bus.all_found  = &w_found;
  assign bus.new_item   = r_newItem;
  assign bus.use_denied = w_deny;
  assign bus.overflow   = w_ovf;

endmodule

// File: tb/tb_item_inventory.sv
// Directed, table-driven self-checking bench for item_inventory (NUM_ITEMS=4, CNT_W=3).
module tb_item_inventory;

  localparam int N = 4;
  localparam int W = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [N-1:0] modelFound;
  logic lastClear;

  item_inventory_if #(.NUM_ITEMS(N), .CNT_W(W)) bus ();

  item_inventory #(.NUM_ITEMS(N), .CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic [N-1:0]  pick;
    logic [N-1:0]  useReq;
    logic [N*W-1:0] expCount;
    logic [N-1:0]  expHave;
    logic          expNew;
    logic [N-1:0]  expDeny;
    logic [N-1:0]  expOvf;
  } vec_t;

  function automatic logic [N*W-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic [N-1:0] p, input logic [N-1:0] u);
    @(negedge clk);
    bus.clear   = clr;
    bus.pick    = p;
    bus.use_req = u;
    lastClear   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [N*W-1:0] expCount, input logic [N-1:0] expHave,
                             input logic expNew, input logic [N-1:0] expDeny, input logic [N-1:0] expOvf);
    logic [N-1:0] expFound;
`ifdef INVENTORY_STICKY_EN
    modelFound = lastClear ? '0 : (modelFound | expHave);
    expFound   = modelFound;
`else
    expFound   = expHave;
`endif
    cmpVal({tag, ".count"},      32'(bus.count),      32'(expCount));
    cmpVal({tag, ".have"},       32'(bus.have),       32'(expHave));
    cmpVal({tag, ".found"},      32'(bus.found),      32'(expFound));
    cmpVal({tag, ".all_found"},  32'(bus.all_found),  32'(&expFound));
    cmpVal({tag, ".new_item"},   32'(bus.new_item),   32'(expNew));
    cmpVal({tag, ".use_denied"}, 32'(bus.use_denied), 32'(expDeny));
    cmpVal({tag, ".overflow"},   32'(bus.overflow),   32'(expOvf));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    checks      = 0;
    failures    = 0;
    modelFound  = '0;
    lastClear   = 1'b0;
    bus.clear   = 1'b0;
    bus.pick    = '0;
    bus.use_req = '0;
    reset       = 1'b1;

    vecs[0] = '{1'b0, 4'b0001, 4'b0000, pk(1,0,0,0), 4'b0001, 1'b1, 4'b0000, 4'b0000};
    vecs[1] = '{1'b0, 4'b0000, 4'b0000, pk(1,0,0,0), 4'b0001, 1'b0, 4'b0000, 4'b0000};
    vecs[2] = '{1'b0, 4'b0000, 4'b0100, pk(1,0,0,0), 4'b0001, 1'b0, 4'b0100, 4'b0000};
    vecs[3] = '{1'b0, 4'b0100, 4'b0100, pk(1,0,0,0), 4'b0001, 1'b0, 4'b0000, 4'b0000};
    vecs[4] = '{1'b0, 4'b1111, 4'b0000, pk(2,1,1,1), 4'b1111, 1'b1, 4'b0000, 4'b0000};
    vecs[5] = '{1'b0, 4'b0000, 4'b1000, pk(2,1,1,0), 4'b0111, 1'b0, 4'b0000, 4'b0000};
    vecs[6] = '{1'b0, 4'b0001, 4'b0001, pk(2,1,1,0), 4'b0111, 1'b0, 4'b0000, 4'b0000};
    vecs[7] = '{1'b0, 4'b0000, 4'b0011, pk(1,0,1,0), 4'b0101, 1'b0, 4'b0000, 4'b0000};
    vecs[8] = '{1'b0, 4'b0000, 4'b0011, pk(0,0,1,0), 4'b0100, 1'b0, 4'b0010, 4'b0000};

    #12;
    checkOutput("reset", '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].pick, vecs[i].useReq);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expHave,
                  vecs[i].expNew, vecs[i].expDeny, vecs[i].expOvf);
    end

    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput("clear", '0, '0, 1'b0, '0, '0);

    // Saturation of slot 1: overflow pulses only on picks 8 and 9.
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b0, 4'b0010, 4'b0000);
      checkOutput($sformatf("sat%0d", k), pk(0, (k > 7) ? 7 : k, 0, 0), 4'b0010,
                  (k == 1), 4'b0000, (k > 7) ? 4'b0010 : 4'b0000);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("satIdle", pk(0,7,0,0), 4'b0010, 1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0010, 4'b0010);
    checkOutput("fullUse", pk(0,6,0,0), 4'b0010, 1'b0, 4'b0000, 4'b0000);

    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 4'b0001, 4'b0000);
      checkOutput($sformatf("fill%0d", k), pk(k,6,0,0), 4'b0011, (k == 1), 4'b0000, 4'b0000);
    end
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    checkOutput("clearPick", '0, '0, 1'b0, '0, '0);

    // Reset asserted while a deny pulse is live and a pick burst is being driven.
    applyStimulus(1'b0, 4'b0001, 4'b1000);
    checkOutput("preReset", pk(1,0,0,0), 4'b0001, 1'b1, 4'b1000, 4'b0000);
    bus.pick    = 4'b1111;
    bus.use_req = 4'b0000;
    #1 reset = 1'b1;
    #1;
    modelFound = '0;
    lastClear  = 1'b0;
    checkOutput("asyncReset", '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    bus.pick = '0;
    reset    = 1'b0;
    applyStimulus(1'b0, 4'b0001, 4'b0000);
    checkOutput("postReset", pk(1,0,0,0), 4'b0001, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("postResetIdle", pk(1,0,0,0), 4'b0001, 1'b0, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
